// File: rtl/zfifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter (state encoding, parity modes).
package zfifo_uart_tx_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_t;

  // Parity mode values accepted by PARITY_EN.
  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;

endpackage

// File: rtl/zuart_bit_timer.sv
// UART bit-period timer.
// Counts 0..CLKS_PER_BIT-1 while iRun is high and wraps; iStart clears the count.
//   iClk, iRstN   clock / async active-low reset
//   iStart        synchronous clear (takes priority over iRun)
//   iRun          advance the counter this cycle
//   oTick_c       terminal count reached (last clock of the bit)
//   oPreTick_c    one clock before terminal count
module zuart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic iClk,
  input  logic iRstN,
  input  logic iStart,
  input  logic iRun,
  output logic oTick_c,
  output logic oPreTick_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt;

  // Bit-period counter
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      cnt <= '0;
    end else if (iStart) begin
      cnt <= '0;
    end else if (iRun) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign oTick_c    = iRun && (cnt == CNT_LAST);
  assign oPreTick_c = iRun && (cnt == CNT_PRE);

endmodule

// File: rtl/zfifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one word per frame from a synchronous FIFO
// and sends start, LSB-first data, optional even parity and 1 or 2 stop bits.
//   iClk, iRstN  clock / async active-low reset
//   iEnable      allow new frames to start
//   iEmpty       FIFO empty flag
//   oRdEn        FIFO pop pulse (one clock per frame)
//   iRdData      FIFO read data, valid the clock after oRdEn
//   oTxd         serial line, idle high
//   oBusy        high whenever the FSM is not idle
//   oFrameDone   pulse in the last clock of the final stop bit
module zfifo_uart_tx
  import zfifo_uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  input  logic                  iEnable,
  input  logic                  iEmpty,
  output logic                  oRdEn,
  input  logic [DATA_WIDTH-1:0] iRdData,
  output logic                  oTxd,
  output logic                  oBusy,
  output logic                  oFrameDone
);

  localparam int unsigned      IDX_W    = $clog2(DATA_WIDTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam bit               PAR_ON   = (PARITY_EN == PARITY_EVEN);
  localparam bit               TWO_STOP = (STOP_BITS == 2);

  state_t                state, stateNext;
  logic [DATA_WIDTH-1:0] shift, shiftNext;
  logic                  parity, parityNext;
  logic [IDX_W-1:0]      bitIdx, bitIdxNext;
  logic                  stopIdx, stopIdxNext;
  logic                  txdNext, rdEnNext, busyNext, frameDoneNext;
  logic                  timerStart_c, timerRun_c, tick_c, preTick_c;

  zuart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uBitTimer (
    .iClk      (iClk),
    .iRstN     (iRstN),
    .iStart    (timerStart_c),
    .iRun      (timerRun_c),
    .oTick_c   (tick_c),
    .oPreTick_c(preTick_c)
  );

  // State, datapath and output registers
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state      <= ST_IDLE;
      shift      <= '0;
      parity     <= 1'b0;
      bitIdx     <= '0;
      stopIdx    <= 1'b0;
      oTxd       <= 1'b1;
      oRdEn      <= 1'b0;
      oBusy      <= 1'b0;
      oFrameDone <= 1'b0;
    end else begin
      state      <= stateNext;
      shift      <= shiftNext;
      parity     <= parityNext;
      bitIdx     <= bitIdxNext;
      stopIdx    <= stopIdxNext;
      oTxd       <= txdNext;
      oRdEn      <= rdEnNext;
      oBusy      <= busyNext;
      oFrameDone <= frameDoneNext;
    end
  end

  // Next-state and next-output logic; outputs are decoded from the next state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    stateNext     = state;
    shiftNext     = shift;
    parityNext    = parity;
    bitIdxNext    = bitIdx;
    stopIdxNext   = stopIdx;
    timerStart_c  = 1'b0;
    timerRun_c    = 1'b0;
    txdNext       = 1'b1;
    rdEnNext      = 1'b0;
    busyNext      = 1'b0;
    frameDoneNext = 1'b0;

    case (state)
      ST_IDLE: begin
        if (iEnable && !iEmpty) stateNext = ST_POP;
      end
      ST_POP: begin
        stateNext = ST_LOAD;
      end
      ST_LOAD: begin
        shiftNext    = iRdData;
        parityNext   = ^iRdData;
        bitIdxNext   = '0;
        stopIdxNext  = 1'b0;
        timerStart_c = 1'b1;
        stateNext    = ST_START;
      end
      ST_START: begin
        timerRun_c = 1'b1;
        if (tick_c) stateNext = ST_DATA;
      end
      ST_DATA: begin
        timerRun_c = 1'b1;
        if (tick_c) begin
          if (bitIdx == LAST_IDX) begin
            stateNext = PAR_ON ? ST_PARITY : ST_STOP;
          end else begin
            bitIdxNext = bitIdx + IDX_W'(1);
            shiftNext  = shift >> 1;
          end
        end
      end
      ST_PARITY: begin
        timerRun_c = 1'b1;
        if (tick_c) stateNext = ST_STOP;
      end
      ST_STOP: begin
        timerRun_c = 1'b1;
        // Registered pulse lands on the last clock of the final stop bit.
        frameDoneNext = preTick_c && (stopIdx == TWO_STOP);
        if (tick_c) begin
          if (TWO_STOP && !stopIdx) begin
            stopIdxNext = 1'b1;
          end else begin
            stateNext = (iEnable && !iEmpty) ? ST_POP : ST_IDLE;
          end
        end
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase

    busyNext = (stateNext != ST_IDLE);
    rdEnNext = (stateNext == ST_POP);
    case (stateNext)
      ST_START:  txdNext = 1'b0;
      ST_DATA:   txdNext = shiftNext[0];
      ST_PARITY: txdNext = parityNext;
      default:   txdNext = 1'b1;
    endcase
  end

endmodule
